// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit shift/rotate unit: one single-bit rotation per clock.
// Optional zero flag output zf_out is enabled by defining SHIFT_SEQ_ZF_EN.
`timescale 1ns/1ps
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cf_out,
`ifdef SHIFT_SEQ_ZF_EN
    output logic             zf_out,
`endif
    output logic [WIDTH-1:0] sh_a,
    output logic             sh_fbus,
    output logic             sh_flbus,
    output logic             sh_frbus,
    input  logic [WIDTH-1:0] sh_w,
    input  logic             sh_cf
);

    // Handshake: start is sampled only in IDLE; busy is high in every other state;
    // done is a one-cycle pulse in DONE, after which the next start is accepted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               cf_q, cf_d;
`ifdef SHIFT_SEQ_ZF_EN
    logic               zf_q, zf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            cf_q    <= 1'b0;
`ifdef SHIFT_SEQ_ZF_EN
            zf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            cf_q    <= cf_d;
`ifdef SHIFT_SEQ_ZF_EN
            zf_q    <= zf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        cf_d    = cf_q;
`ifdef SHIFT_SEQ_ZF_EN
        zf_d    = zf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = din;
                    cnt_d   = count;
                    dir_d   = dir;
                    state_d = (count == '0) ? PASS : SHIFT;
                end
            end
            PASS: begin
                dout_d  = sh_w;
                cf_d    = 1'b0;
`ifdef SHIFT_SEQ_ZF_EN
                zf_d    = (sh_w == '0);
`endif
                state_d = DONE;
            end
            SHIFT: begin
                work_d = sh_w;
                dout_d = sh_w;
                cf_d   = sh_cf;
`ifdef SHIFT_SEQ_ZF_EN
                zf_d   = (sh_w == '0);
`endif
                // Saturate at zero so a corrupted count can never wrap into a long run.
                cnt_d  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Selects decode from registered state only, so they cannot glitch on start/din.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        sh_a     = work_q;
        sh_fbus  = (state_q == PASS);
        sh_flbus = (state_q == SHIFT) && dir_q;
        sh_frbus = (state_q == SHIFT) && !dir_q;
        dout     = dout_q;
        cf_out   = cf_q;
`ifdef SHIFT_SEQ_ZF_EN
        zf_out   = zf_q;
`endif
    end

endmodule
